// File: rtl/parking_pkg.sv
// parking_pkg: shared types and default timing for the parking gate controller.
// Optional build macro: SENSOR_DEBOUNCE_EN (sensor debounce filters).
package parking_pkg;

    localparam int unsigned DEBOUNCE_DEF     = 4;
    localparam int unsigned OPEN_TIMEOUT_DEF = 1000;
    localparam int unsigned CLOSE_CYCLES_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        OPEN,
        PASS_A,
        PASS_AB,
        PASS_B,
        CLOSE
    } gate_state_t;

    typedef struct packed {
        logic valid;
        logic is_uni;
    } gate_event_t;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    // Barrier is raised in every state between the grant and the close.
    function automatic logic gate_is_open(input gate_state_t s);
        return s inside {OPEN, PASS_A, PASS_AB, PASS_B};
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// parking_gate_fsm: one gate - sensor sync, optional debounce, FSM and timer.
// Optional build macro: SENSOR_DEBOUNCE_EN (adds per-sensor debounce filters).
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter bit          IS_ENTRY     = 1'b1,
    parameter int unsigned DEBOUNCE     = DEBOUNCE_DEF,
    parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
    parameter int unsigned CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_card_valid,
    input  logic        i_card_is_uni,
    input  logic        i_sensor_a,
    input  logic        i_sensor_b,
    input  logic        i_uni_space,
    input  logic        i_gen_space,
    output logic        o_barrier_open,
    output logic        o_denied,
    output gate_event_t o_event
);

    localparam int unsigned TW =
        $clog2(max_u(OPEN_TIMEOUT, CLOSE_CYCLES) + 1);
    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

    // bit 1 = beam a (outer), bit 0 = beam b (inner)
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_sens;

    gate_state_t r_state;
    gate_state_t w_state_nxt;
    logic [TW-1:0] r_timer;
    logic        r_is_uni;
    logic        r_barrier;
    logic        r_denied;
    gate_event_t r_event;

    logic        w_deny;
    logic        w_evt;
    logic        w_space;
    logic        w_a;
    logic        w_b;

    // Two-flop synchroniser for both asynchronous beams
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_sensor_a, i_sensor_b};
            r_sync2 <= r_sync1;
        end
    end

`ifdef SENSOR_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    r_filt;
    logic [CW-1:0] r_db_cnt [2];

    // Filtered beam follows the synchronised one after DEBOUNCE equal samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_filt[i]   <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_sens = r_filt;
`else
    assign w_sens = r_sync2;
`endif

    assign w_a     = w_sens[1];
    assign w_b     = w_sens[0];
    assign w_space = r_is_uni ? i_uni_space : i_gen_space;

    // Next-state logic; exit gate never refuses a card
    always_comb begin
        w_state_nxt = r_state;
        w_deny      = 1'b0;
        w_evt       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_card_valid) w_state_nxt = CHECK;
            end
            CHECK: begin
                if (IS_ENTRY && !w_space) begin
                    w_state_nxt = IDLE;
                    w_deny      = 1'b1;
                end else begin
                    w_state_nxt = OPEN;
                end
            end
            OPEN: begin
                if (w_a) begin
                    w_state_nxt = PASS_A;
                end else if (r_timer == OPEN_LAST) begin
                    w_state_nxt = CLOSE;
                end
            end
            PASS_A: begin
                if (w_a && w_b) begin
                    w_state_nxt = PASS_AB;
                end else if (!w_a && !w_b) begin
                    w_state_nxt = OPEN;
                end
            end
            PASS_AB: begin
                if (!w_a && w_b) begin
                    w_state_nxt = PASS_B;
                end else if (w_a && !w_b) begin
                    w_state_nxt = PASS_A;
                end
            end
            PASS_B: begin
                if (!w_a && !w_b) begin
                    w_state_nxt = CLOSE;
                    w_evt       = 1'b1;
                end else if (w_a && w_b) begin
                    w_state_nxt = PASS_AB;
                end
            end
            CLOSE: begin
                if (r_timer == CLOSE_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; class latched only when a card is taken in IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_is_uni <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && i_card_valid) begin
                r_is_uni <= i_card_is_uni;
            end
        end
    end

    // Timer restarts on every state change and saturates instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if (r_timer != {TW{1'b1}}) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Registered gate outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_barrier <= 1'b0;
            r_denied  <= 1'b0;
            r_event   <= '0;
        end else begin
            r_barrier <= gate_is_open(w_state_nxt);
            r_denied  <= w_deny;
            r_event   <= '{valid: w_evt, is_uni: r_is_uni & w_evt};
        end
    end

    assign o_barrier_open = r_barrier;
    assign o_denied       = r_denied;
    assign o_event        = r_event;

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entry and exit gates plus occupancy event arbiter.
// Optional build macro: SENSOR_DEBOUNCE_EN (sensor debounce filters).
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE     = DEBOUNCE_DEF,
    parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
    parameter int unsigned CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic entry_card_valid,
    input  logic entry_card_is_uni,
    input  logic entry_sensor_a,
    input  logic entry_sensor_b,
    input  logic exit_card_valid,
    input  logic exit_card_is_uni,
    input  logic exit_sensor_a,
    input  logic exit_sensor_b,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_barrier_open,
    output logic exit_barrier_open,
    output logic entry_denied
);

    gate_event_t w_ent_evt;
    gate_event_t w_ext_evt;
    gate_event_t r_pend;
    logic        w_ent_denied;
    logic        w_ext_denied;
    logic        w_collide;

    logic r_car_entered;
    logic r_uni_entered;
    logic r_car_exited;
    logic r_uni_exited;

    parking_gate_fsm #(
        .IS_ENTRY     (1'b1),
        .DEBOUNCE     (DEBOUNCE),
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES)
    ) u_entry (
        .i_clk          (clk),
        .i_rst_n        (reset_n),
        .i_card_valid   (entry_card_valid),
        .i_card_is_uni  (entry_card_is_uni),
        .i_sensor_a     (entry_sensor_a),
        .i_sensor_b     (entry_sensor_b),
        .i_uni_space    (uni_is_vacated_space),
        .i_gen_space    (is_vacated_space),
        .o_barrier_open (entry_barrier_open),
        .o_denied       (w_ent_denied),
        .o_event        (w_ent_evt)
    );

    parking_gate_fsm #(
        .IS_ENTRY     (1'b0),
        .DEBOUNCE     (DEBOUNCE),
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES)
    ) u_exit (
        .i_clk          (clk),
        .i_rst_n        (reset_n),
        .i_card_valid   (exit_card_valid),
        .i_card_is_uni  (exit_card_is_uni),
        .i_sensor_a     (exit_sensor_a),
        .i_sensor_b     (exit_sensor_b),
        .i_uni_space    (uni_is_vacated_space),
        .i_gen_space    (is_vacated_space),
        .o_barrier_open (exit_barrier_open),
        .o_denied       (w_ext_denied),
        .o_event        (w_ext_evt)
    );

    // Exit gate never refuses, so its denied line is constant low
    assign entry_denied = w_ent_denied | w_ext_denied;

    // Counter drops one update if both same-class pulses land together
    assign w_collide = w_ent_evt.valid & w_ext_evt.valid
                     & (w_ent_evt.is_uni == w_ext_evt.is_uni);

    // Arbiter: entry issues at once, a colliding exit is deferred one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_car_entered <= 1'b0;
            r_uni_entered <= 1'b0;
            r_car_exited  <= 1'b0;
            r_uni_exited  <= 1'b0;
            r_pend        <= '0;
        end else begin
            r_car_entered <= w_ent_evt.valid;
            r_uni_entered <= w_ent_evt.valid & w_ent_evt.is_uni;
            if (r_pend.valid) begin
                r_car_exited <= 1'b1;
                r_uni_exited <= r_pend.is_uni;
                r_pend       <= '0;
            end else if (w_collide) begin
                r_car_exited <= 1'b0;
                r_uni_exited <= 1'b0;
                r_pend       <= w_ext_evt;
            end else begin
                r_car_exited <= w_ext_evt.valid;
                r_uni_exited <= w_ext_evt.valid & w_ext_evt.is_uni;
            end
        end
    end

    assign car_entered        = r_car_entered;
    assign is_uni_car_entered = r_uni_entered;
    assign car_exited         = r_car_exited;
    assign is_uni_car_exited  = r_uni_exited;

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: scenario tasks with an event scoreboard.
// Works with and without SENSOR_DEBOUNCE_EN defined.
module tb_parking_gate_controller;

    localparam int OPEN_TIMEOUT = 1000;
    localparam int CLOSE_CYCLES = 8;
    localparam int DEBOUNCE     = 4;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int EXTRA = DEBOUNCE;
`else
    localparam int EXTRA = 0;
`endif
    // sensor edge -> sync(2) -> filter -> FSM edge -> arbiter edge
    localparam int EVT_LAT = 4 + EXTRA;

    logic clk;
    logic reset_n;
    logic entry_card_valid;
    logic entry_card_is_uni;
    logic entry_sensor_a;
    logic entry_sensor_b;
    logic exit_card_valid;
    logic exit_card_is_uni;
    logic exit_sensor_a;
    logic exit_sensor_b;
    logic uni_is_vacated_space;
    logic is_vacated_space;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic entry_barrier_open;
    logic exit_barrier_open;
    logic entry_denied;

    parking_gate_controller #(
        .DEBOUNCE     (DEBOUNCE),
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .entry_card_valid     (entry_card_valid),
        .entry_card_is_uni    (entry_card_is_uni),
        .entry_sensor_a       (entry_sensor_a),
        .entry_sensor_b       (entry_sensor_b),
        .exit_card_valid      (exit_card_valid),
        .exit_card_is_uni     (exit_card_is_uni),
        .exit_sensor_a        (exit_sensor_a),
        .exit_sensor_b        (exit_sensor_b),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_barrier_open   (entry_barrier_open),
        .exit_barrier_open    (exit_barrier_open),
        .entry_denied         (entry_denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit is_uni;
        int cyc;
    } exp_t;

    exp_t ent_q[$];
    exp_t ext_q[$];
    exp_t mon_e;
    int   vec = 0;
    int   err = 0;

    // Scoreboard: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (car_entered === 1'b1) begin
            vec++;
            if (ent_q.size() == 0) begin
                err++;
                $display("FAIL entered_unexpected: pulse at cyc %0d, none required",
                         cyc);
            end else begin
                mon_e = ent_q.pop_front();
                if (is_uni_car_entered !== mon_e.is_uni || cyc != mon_e.cyc) begin
                    err++;
                    $display("FAIL entered: uni=%b cyc=%0d, required uni=%b cyc=%0d",
                             is_uni_car_entered, cyc, mon_e.is_uni, mon_e.cyc);
                end
            end
        end
        if (car_exited === 1'b1) begin
            vec++;
            if (ext_q.size() == 0) begin
                err++;
                $display("FAIL exited_unexpected: pulse at cyc %0d, none required",
                         cyc);
            end else begin
                mon_e = ext_q.pop_front();
                if (is_uni_car_exited !== mon_e.is_uni || cyc != mon_e.cyc) begin
                    err++;
                    $display("FAIL exited: uni=%b cyc=%0d, required uni=%b cyc=%0d",
                             is_uni_car_exited, cyc, mon_e.is_uni, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic card(input bit en, input bit en_uni,
                        input bit ex, input bit ex_uni,
                        output int t);
        @(negedge clk);
        entry_card_valid  = en;
        entry_card_is_uni = en_uni;
        exit_card_valid   = ex;
        exit_card_is_uni  = ex_uni;
        t = cyc;
        @(negedge clk);
        entry_card_valid = 1'b0;
        exit_card_valid  = 1'b0;
    endtask

    task automatic drive(input logic [1:0] en_ab, input logic [1:0] ex_ab,
                         input int hold);
        @(negedge clk);
        entry_sensor_a = en_ab[1];
        entry_sensor_b = en_ab[0];
        exit_sensor_a  = ex_ab[1];
        exit_sensor_b  = ex_ab[0];
        repeat (hold - 1) @(negedge clk);
    endtask

    // Full pass a, ab, b, none; expectations pushed when the last step is driven
    task automatic pass_seq(input bit sel_en, input bit sel_ex,
                            input bit en_uni, input bit ex_uni,
                            input int ex_delay);
        logic [1:0] seq [3];
        int t;
        seq[0] = 2'b10;
        seq[1] = 2'b11;
        seq[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            drive(sel_en ? seq[i] : 2'b00, sel_ex ? seq[i] : 2'b00, 10);
        end
        @(negedge clk);
        entry_sensor_a = 1'b0;
        entry_sensor_b = 1'b0;
        exit_sensor_a  = 1'b0;
        exit_sensor_b  = 1'b0;
        t = cyc;
        if (sel_en) ent_q.push_back('{en_uni, t + EVT_LAT});
        if (sel_ex) ext_q.push_back('{ex_uni, t + EVT_LAT + ex_delay});
        tick(20);
    endtask

    task automatic test_reset;
        reset_n              = 1'b0;
        entry_card_valid     = 1'b0;
        entry_card_is_uni    = 1'b0;
        entry_sensor_a       = 1'b0;
        entry_sensor_b       = 1'b0;
        exit_card_valid      = 1'b0;
        exit_card_is_uni     = 1'b0;
        exit_sensor_a        = 1'b0;
        exit_sensor_b        = 1'b0;
        uni_is_vacated_space = 1'b1;
        is_vacated_space     = 1'b1;
        tick(3);
        vec++;
        if ({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
             entry_barrier_open, exit_barrier_open, entry_denied} !== 7'b0) begin
            err++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {car_entered, is_uni_car_entered, car_exited,
                      is_uni_car_exited, entry_barrier_open,
                      exit_barrier_open, entry_denied});
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_entry_uni;
        int c;
        card(1'b1, 1'b1, 1'b0, 1'b0, c);
        vec++;
        if (entry_barrier_open !== 1'b0) begin
            err++;
            $display("FAIL uni_barrier_early: got %b, required 0", entry_barrier_open);
        end
        tick();
        vec++;
        if (entry_barrier_open !== 1'b1) begin
            err++;
            $display("FAIL uni_barrier_open: got %b, required 1", entry_barrier_open);
        end
        pass_seq(1'b1, 1'b0, 1'b1, 1'b0, 0);
        vec++;
        if (entry_barrier_open !== 1'b0) begin
            err++;
            $display("FAIL uni_barrier_after: got %b, required 0", entry_barrier_open);
        end
        vec++;
        if (ent_q.size() != 0 || ext_q.size() != 0) begin
            err++;
            $display("FAIL uni_missing: %0d/%0d pending, required 0/0",
                     ent_q.size(), ext_q.size());
            ent_q.delete();
            ext_q.delete();
        end
    endtask

    task automatic test_denied;
        int c;
        int hi;
        int dn;
        is_vacated_space = 1'b0;
        card(1'b1, 1'b0, 1'b0, 1'b0, c);
        vec++;
        if (entry_denied !== 1'b0) begin
            err++;
            $display("FAIL denied_early: got %b, required 0", entry_denied);
        end
        tick();
        vec++;
        if (entry_denied !== 1'b1) begin
            err++;
            $display("FAIL denied_pulse: got %b, required 1", entry_denied);
        end
        hi = 0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (entry_barrier_open === 1'b1) hi++;
            if (entry_denied === 1'b1) dn++;
        end
        vec++;
        if (hi != 0 || dn != 0) begin
            err++;
            $display("FAIL denied_after: barrier %0d denied %0d, required 0 0",
                     hi, dn);
        end
        is_vacated_space = 1'b1;
    endtask

    task automatic test_timeout;
        int c;
        int n;
        card(1'b1, 1'b0, 1'b0, 1'b0, c);
        tick();
        n = 0;
        while (entry_barrier_open === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        vec++;
        if (n != OPEN_TIMEOUT) begin
            err++;
            $display("FAIL timeout_len: open %0d cycles, required %0d",
                     n, OPEN_TIMEOUT);
        end
        // card sampled on the last CLOSE edge must be ignored
        tick(CLOSE_CYCLES - 2);
        card(1'b1, 1'b0, 1'b0, 1'b0, c);
        tick(2);
        vec++;
        if (entry_barrier_open !== 1'b0) begin
            err++;
            $display("FAIL close_ignore: got %b, required 0", entry_barrier_open);
        end
    endtask

    task automatic test_glitch;
        int c;
        int n;
        card(1'b1, 1'b0, 1'b0, 1'b0, c);
        tick();
        n = 1;
        tick(99);
        drive(2'b10, 2'b00, 2);
        drive(2'b00, 2'b00, 1);
        n += 102;
        while (entry_barrier_open === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        n--;
        vec++;
`ifdef SENSOR_DEBOUNCE_EN
        if (n != OPEN_TIMEOUT) begin
            err++;
            $display("FAIL glitch_filtered: open %0d cycles, required %0d",
                     n, OPEN_TIMEOUT);
        end
`else
        if (n <= OPEN_TIMEOUT) begin
            err++;
            $display("FAIL glitch_seen: open %0d cycles, required > %0d",
                     n, OPEN_TIMEOUT);
        end
`endif
        // first edge after CLOSE completes finds the gate IDLE
        tick(CLOSE_CYCLES - 1);
        card(1'b1, 1'b0, 1'b0, 1'b0, c);
        tick();
        vec++;
        if (entry_barrier_open !== 1'b1) begin
            err++;
            $display("FAIL idle_accept: got %b, required 1", entry_barrier_open);
        end
        n = 0;
        while (entry_barrier_open === 1'b1 && n < 1100) begin
            n++;
            tick();
        end
        tick(CLOSE_CYCLES + 2);
    endtask

    task automatic test_reverse;
        int c;
        card(1'b1, 1'b0, 1'b0, 1'b0, c);
        tick();
        drive(2'b10, 2'b00, 10);
        drive(2'b11, 2'b00, 10);
        drive(2'b10, 2'b00, 10);
        drive(2'b00, 2'b00, 20);
        vec++;
        if (entry_barrier_open !== 1'b1) begin
            err++;
            $display("FAIL reverse_open: got %b, required 1", entry_barrier_open);
        end
        pass_seq(1'b1, 1'b0, 1'b0, 1'b0, 0);
        vec++;
        if (entry_barrier_open !== 1'b0 || ent_q.size() != 0) begin
            err++;
            $display("FAIL reverse_done: barrier %b pending %0d, required 0 0",
                     entry_barrier_open, ent_q.size());
            ent_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        int c;
        card(1'b1, 1'b0, 1'b1, 1'b0, c);
        tick();
        vec++;
        if ({entry_barrier_open, exit_barrier_open} !== 2'b11) begin
            err++;
            $display("FAIL b2b_gen_open: got %b, required 11",
                     {entry_barrier_open, exit_barrier_open});
        end
        pass_seq(1'b1, 1'b1, 1'b0, 1'b0, 1);
        vec++;
        if (ent_q.size() != 0 || ext_q.size() != 0) begin
            err++;
            $display("FAIL b2b_gen_missing: %0d/%0d pending, required 0/0",
                     ent_q.size(), ext_q.size());
            ent_q.delete();
            ext_q.delete();
        end
        is_vacated_space = 1'b0;
        card(1'b1, 1'b1, 1'b1, 1'b0, c);
        tick();
        vec++;
        if ({entry_barrier_open, exit_barrier_open} !== 2'b11) begin
            err++;
            $display("FAIL b2b_mix_open: got %b, required 11",
                     {entry_barrier_open, exit_barrier_open});
        end
        pass_seq(1'b1, 1'b1, 1'b1, 1'b0, 0);
        vec++;
        if (ent_q.size() != 0 || ext_q.size() != 0) begin
            err++;
            $display("FAIL b2b_mix_missing: %0d/%0d pending, required 0/0",
                     ent_q.size(), ext_q.size());
            ent_q.delete();
            ext_q.delete();
        end
        is_vacated_space = 1'b1;
    endtask

    task automatic test_reset_mid;
        int c;
        card(1'b1, 1'b0, 1'b1, 1'b1, c);
        tick();
        drive(2'b10, 2'b10, 10);
        drive(2'b11, 2'b11, 10);
        #2;
        reset_n = 1'b0;
        #1;
        vec++;
        if ({entry_barrier_open, exit_barrier_open} !== 2'b00) begin
            err++;
            $display("FAIL reset_drop: got %b, required 00",
                     {entry_barrier_open, exit_barrier_open});
        end
        tick(3);
        reset_n = 1'b1;
        drive(2'b01, 2'b01, 10);
        drive(2'b00, 2'b00, 20);
        vec++;
        if ({entry_barrier_open, exit_barrier_open} !== 2'b00) begin
            err++;
            $display("FAIL reset_after: got %b, required 00",
                     {entry_barrier_open, exit_barrier_open});
        end
    endtask

    initial begin
        test_reset();
        test_entry_uni();
        test_denied();
        test_timeout();
        test_glitch();
        test_reverse();
        test_back_to_back();
        test_reset_mid();
        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
